oled_pixel_streamer: RTL
========================

OLED_PIXEL_STREAMER -- requirements
Module: oled_pixel_streamer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: clock cycles per serial bit; even, >=2.
REQ-002 SHALL have parameter NUM_PIXELS, default 6144: pixels per frame (96x64).
REQ-003 SHALL have parameter FRAME_GAP, default 64: idle cycles between frames, >=1.
REQ-004 SHALL have port clock_100mhz, input, 1: the single clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port enable, input, 1: permits frame start.
REQ-007 SHALL have port pixel_data, input, 16: RGB565 pixel for the current pixel_index.
REQ-008 SHALL have port pixel_index, output, 13: linear index, y*96+x.
REQ-009 SHALL have port sample_pixel, output, 1: one-cycle pulse when pixel_data is captured.
REQ-010 SHALL have port frame_begin, output, 1: one-cycle pulse at frame start.
REQ-011 SHALL have port sending_pixels, output, 1: high while pixel words are shifting.
REQ-012 SHALL have ports cs, sdin, sclk, d_cn, all output, 1: serial chip select (active low), data, bit clock, data/command select (0 = command).

Function
REQ-013 SHALL implement the states IDLE, CMD, PIX and GAP.
- IDLE->CMD when enable=1.
- CMD->PIX after the last command bit.
- PIX->GAP after the last bit of pixel NUM_PIXELS-1.
- GAP->CMD after FRAME_GAP cycles if enable=1; otherwise GAP->IDLE.
REQ-014 SHALL send, in CMD, the bytes 0x15,0x00,0x5F,0x75,0x00,0x3F in that order, MSB first, with d_cn=0.
REQ-015 SHALL send, in PIX, NUM_PIXELS 16-bit words MSB first with d_cn=1 and no gap between words.
REQ-016 Bit timing:
- Each bit SHALL last exactly CLK_DIV cycles.
- sclk SHALL be low for the first CLK_DIV/2 cycles and high for the remaining cycles.
- sdin SHALL change only in the first cycle of a bit.
REQ-017 cs SHALL be 0 throughout CMD and PIX, and 1 in IDLE and GAP.
REQ-018 sclk SHALL be 1 and sdin 0 in IDLE and GAP.
REQ-019 frame_begin SHALL pulse for one cycle on the cycle entering CMD.
REQ-020 sending_pixels SHALL equal (state==PIX).
REQ-021 Pixel prefetch:
- pixel_index SHALL be 0 from CMD entry.
- pixel_index SHALL advance by 1 in the first cycle of each pixel word.
- pixel_index therefore leads the transmitted word by one word.
REQ-022 sample_pixel SHALL pulse, and pixel_data SHALL load into the shift register, in the last cycle of the preceding word (last CMD bit for pixel 0); pixel_data SHALL be treated as valid at that edge.
REQ-023 After the final word, pixel_index SHALL hold NUM_PIXELS-1; it SHALL return to 0 on the next CMD entry and SHALL never exceed NUM_PIXELS-1.
REQ-024 enable deasserting mid-frame SHALL NOT truncate the frame; it only blocks the next frame start.
REQ-025 pixel_data changes between sample points SHALL have no effect on transmitted data.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL enter IDLE with: cs=1, sclk=1, sdin=0, d_cn=0, pixel_index=0, sample_pixel=0, frame_begin=0, sending_pixels=0, all counters 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately with no partial-bit completion; it has priority over all other inputs.

Configuration
REQ-028 With macro OLED_STREAM_CMD_EN defined, CMD SHALL be included as specified above.
REQ-029 Without OLED_STREAM_CMD_EN:
- CMD SHALL be omitted; IDLE/GAP SHALL go directly to PIX.
- frame_begin SHALL pulse on PIX entry.
- pixel 0 SHALL be sampled in the PIX-entry cycle and its first bit sent one cycle later.
- d_cn SHALL be held 1.

Verification
REQ-030 Command preamble: CLK_DIV=2, CMD_EN defined, enable=1 after reset -> frame_begin one pulse; sdin across 48 sclk rising edges decodes 15 00 5F 75 00 3F with d_cn=0, cs=0.
REQ-031 Pixel stream: NUM_PIXELS=4, pixel_data=0xA000+pixel_index -> words A000,A001,A002,A003 with d_cn=1; exactly 4 sample_pixel pulses; sending_pixels high for 128 cycles.
REQ-032 Gap and repeat: FRAME_GAP=5, enable held -> cs=1 for exactly 5 cycles between frames; second frame_begin follows; pixel_index restarts at 0.
REQ-033 Enable drop: deassert enable at pixel 1 of 4 -> all 4 words still sent; after GAP the block stays in IDLE with cs=1.
REQ-034 Mid-frame reset: reset=1 during pixel 2 -> next cycle cs=1, sclk=1, pixel_index=0, sending_pixels=0; a new frame then starts cleanly.
REQ-035 No-CMD build: OLED_STREAM_CMD_EN undefined -> first sclk rising edge carries pixel 0 MSB; d_cn=1 throughout.

Source files
------------

// File: rtl/oled_pixel_streamer.sv
// Serial pixel pusher for a 96x64 RGB565 OLED: frames of MSB-first 16-bit words on cs/sclk/sdin.
// Build option OLED_STREAM_CMD_EN adds the column/row window command preamble before every frame.
module oled_pixel_streamer #(
   parameter int CLK_DIV    = 8,
   parameter int NUM_PIXELS = 6144,
   parameter int FRAME_GAP  = 64
) (
   input  logic        clock_100mhz,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] pixel_data,
   output logic [12:0] pixel_index,
   output logic        sample_pixel,
   output logic        frame_begin,
   output logic        sending_pixels,
   output logic        cs,
   output logic        sdin,
   output logic        sclk,
   output logic        d_cn
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int GAP_W = $clog2(FRAME_GAP + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(FRAME_GAP - 1);
   localparam logic [12:0]      WORD_LAST = 13'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      PIX  = 2'd2,
      GAP  = 2'd3
   } state_t;

`ifdef OLED_STREAM_CMD_EN
   localparam state_t      START_ST = CMD;
   localparam logic [47:0] CMD_SEQ  = 48'h15_00_5F_75_00_3F;
`else
   localparam state_t      START_ST = PIX;
`endif

   state_t      state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]  bit_q, bit_d;
   logic [12:0] word_q, word_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic        pre_q, pre_d;
   logic [15:0] shreg_q, shreg_d;
   logic        start;

   logic [12:0] pixel_index_q, pixel_index_d;
   logic        sample_pixel_q, sample_pixel_d;
   logic        frame_begin_q, frame_begin_d;
   logic        sending_pixels_q, sending_pixels_d;
   logic        cs_q, cs_d;
   logic        sdin_q, sdin_d;
   logic        sclk_q, sclk_d;
`ifdef OLED_STREAM_CMD_EN
   logic        d_cn_q, d_cn_d;
`endif

   // True in the cycle whose closing edge captures the next pixel word.
   function automatic logic load_point(input state_t st, input logic [DIV_W-1:0] dv,
                                       input logic [5:0] bt, input logic [12:0] wd,
                                       input logic pre);
      logic at_bit_end;
      at_bit_end = (dv == DIV_LAST);
      case (st)
         CMD:     load_point = at_bit_end && (bt == 6'd47);
         PIX:     load_point = pre || (at_bit_end && (bt == 6'd15) && (wd != WORD_LAST));
         default: load_point = 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      word_d  = word_q;
      gap_d   = gap_q;
      pre_d   = 1'b0;
      shreg_d = shreg_q;
      start   = 1'b0;
      case (state_q)
         IDLE: start = enable;
         CMD: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (bit_q == 6'd47) begin
                  state_d = PIX;
                  bit_d   = '0;
                  word_d  = '0;
               end else begin
                  bit_d = bit_q + 6'd1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         PIX: begin
            if (!pre_q) begin
               if (div_q == DIV_LAST) begin
                  div_d = '0;
                  if (bit_q == 6'd15) begin
                     bit_d = '0;
                     if (word_q == WORD_LAST) begin
                        state_d = GAP;
                        gap_d   = '0;
                     end else begin
                        word_d = word_q + 13'd1;
                     end
                  end else begin
                     bit_d   = bit_q + 6'd1;
                     shreg_d = {shreg_q[14:0], 1'b0};
                  end
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               start = enable;
               if (!enable) state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = START_ST;
         div_d   = '0;
         bit_d   = '0;
         word_d  = '0;
         pre_d   = (START_ST == PIX);
      end
      if (load_point(state_q, div_q, bit_q, word_q, pre_q)) shreg_d = pixel_data;
   end

   // Outputs are computed from next-cycle values so the registered copies line up with the state.
   always_comb begin
      cs_d             = !((state_d == CMD) || (state_d == PIX));
      sclk_d           = 1'b1;
      sdin_d           = 1'b0;
      if ((state_d == CMD) || ((state_d == PIX) && !pre_d)) sclk_d = (div_d >= DIV_HALF);
      if ((state_d == PIX) && !pre_d) sdin_d = shreg_d[15];
`ifdef OLED_STREAM_CMD_EN
      if (state_d == CMD) sdin_d = CMD_SEQ[6'd47 - bit_d];
      d_cn_d           = (state_d == PIX);
`endif
      sending_pixels_d = (state_d == PIX);
      frame_begin_d    = start;
      sample_pixel_d   = load_point(state_d, div_d, bit_d, word_d, pre_d);
      pixel_index_d    = pixel_index_q;
      if (start) begin
         pixel_index_d = '0;
      end else if ((state_d == PIX) && !pre_d && (div_d == '0) && (bit_d == '0)) begin
         pixel_index_d = (word_d == WORD_LAST) ? WORD_LAST : (word_d + 13'd1);
      end
   end

   always_ff @(posedge clock_100mhz) begin
      if (reset) begin
         state_q          <= IDLE;
         div_q            <= '0;
         bit_q            <= '0;
         word_q           <= '0;
         gap_q            <= '0;
         pre_q            <= 1'b0;
         pixel_index_q    <= '0;
         sample_pixel_q   <= 1'b0;
         frame_begin_q    <= 1'b0;
         sending_pixels_q <= 1'b0;
         cs_q             <= 1'b1;
         sdin_q           <= 1'b0;
         sclk_q           <= 1'b1;
`ifdef OLED_STREAM_CMD_EN
         d_cn_q           <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         div_q            <= div_d;
         bit_q            <= bit_d;
         word_q           <= word_d;
         gap_q            <= gap_d;
         pre_q            <= pre_d;
         pixel_index_q    <= pixel_index_d;
         sample_pixel_q   <= sample_pixel_d;
         frame_begin_q    <= frame_begin_d;
         sending_pixels_q <= sending_pixels_d;
         cs_q             <= cs_d;
         sdin_q           <= sdin_d;
         sclk_q           <= sclk_d;
`ifdef OLED_STREAM_CMD_EN
         d_cn_q           <= d_cn_d;
`endif
      end
   end

   always_ff @(posedge clock_100mhz) begin
      shreg_q <= shreg_d;
   end

   assign pixel_index    = pixel_index_q;
   assign sample_pixel   = sample_pixel_q;
   assign frame_begin    = frame_begin_q;
   assign sending_pixels = sending_pixels_q;
   assign cs             = cs_q;
   assign sdin           = sdin_q;
   assign sclk           = sclk_q;
`ifdef OLED_STREAM_CMD_EN
   assign d_cn           = d_cn_q;
`else
   assign d_cn           = 1'b1;
`endif

endmodule
